// File: rtl/mips_pkg.sv
// Shared constants and loader state encoding for the MIPS boot-time
// instruction-memory loader.
package mips_pkg;

  localparam int INSTR_WIDTH    = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_WIDTH      = 16;
  localparam int BYTE_WIDTH     = 8;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t ST_IDLE   = 3'd0;
  localparam loader_state_t ST_LEN_HI = 3'd1;
  localparam loader_state_t ST_LEN_LO = 3'd2;
  localparam loader_state_t ST_DATA   = 3'd3;
  localparam loader_state_t ST_CSUM   = 3'd4;
  localparam loader_state_t ST_DONE   = 3'd5;
  localparam loader_state_t ST_ERROR  = 3'd6;

  // States in which a frame byte may be consumed.
  function automatic logic is_loading(input loader_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
           (s == ST_DATA)   || (s == ST_CSUM);
  endfunction

  // States from which a start request begins a new load.
  function automatic logic is_restartable(input loader_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The master modport is the loader's view; the slave modport is its peer.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/loader_word_assembler.sv
// Collects big-endian stream bytes into instruction words; word_valid
// flags the cycle whose byte completes a word, with the full word on word.
module loader_word_assembler
  import mips_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   byte_valid,
  input  logic [BYTE_WIDTH-1:0]  byte_data,
  output logic                   word_valid,
  output logic [INSTR_WIDTH-1:0] word
);

  localparam int CNT_WIDTH = $clog2(BYTES_PER_WORD);
  localparam int SH_WIDTH  = INSTR_WIDTH - BYTE_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_BYTE = CNT_WIDTH'(BYTES_PER_WORD - 1);

  logic [CNT_WIDTH-1:0] byte_cnt;
  logic [SH_WIDTH-1:0]  shreg;

  // The first byte of a word is its most significant, so earlier bytes
  // shift up as later ones arrive.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 1'b1;
      shreg    <= {shreg[SH_WIDTH-BYTE_WIDTH-1:0], byte_data};
    end
  end

  assign word_valid = byte_valid && (byte_cnt == LAST_BYTE);
  assign word       = {shreg, byte_data};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/data/checksum byte frame, writes words to
// instruction memory and releases the CPU from reset on a good checksum.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  imem_loader_if.master         bus,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [LEN_WIDTH:0] MAX_WORDS = (LEN_WIDTH + 1)'(1) << ADDR_WIDTH;

  loader_state_t          state;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [BYTE_WIDTH-1:0]  acc;
  logic                   xfer;
  logic                   start_ok;
  logic                   word_valid;
  logic [INSTR_WIDTH-1:0] word;
  logic [LEN_WIDTH-1:0]   len_n;
  logic [ADDR_WIDTH:0]    words_next;
  logic                   last_word;
  logic                   oversize;

  assign xfer       = bus.in_valid & bus.in_ready;
  assign start_ok   = start & is_restartable(state);
  assign len_n      = {len_q[LEN_WIDTH-1 -: BYTE_WIDTH], bus.in_data};
  assign oversize   = {1'b0, len_n} > MAX_WORDS;
  assign words_next = words_loaded + 1'b1;
  assign last_word  = ((LEN_WIDTH + 1)'(words_next) == {1'b0, len_q});

  loader_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_valid (xfer && (state == ST_DATA)),
    .byte_data  (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Frame sequencing. The length compare is done on the incoming low byte
  // so an oversize frame is rejected without entering DATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      len_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state <= ST_LEN_HI;
            len_q <= '0;
          end
        end
        ST_LEN_HI: begin
          if (xfer) begin
            len_q[LEN_WIDTH-1 -: BYTE_WIDTH] <= bus.in_data;
            state <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (xfer) begin
            len_q <= len_n;
            if (oversize)
              state <= ST_ERROR;
            else if (len_n == '0)
              state <= ST_CSUM;
            else
              state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (word_valid && last_word)
            state <= ST_CSUM;
        end
        ST_CSUM: begin
          if (xfer)
            state <= (bus.in_data == acc) ? ST_DONE : ST_ERROR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Running XOR over every frame byte ahead of the checksum byte.
  always_ff @(posedge clk) begin
    if (reset || start_ok)
      acc <= '0;
    else if (xfer && (state != ST_CSUM))
      acc <= acc ^ bus.in_data;
  end

  // Memory write port: the strobe is a single registered pulse following
  // the byte that completes a word, so a reset clears any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      words_loaded   <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (start_ok) begin
        words_loaded <= '0;
      end else if ((state == ST_DATA) && word_valid) begin
        bus.imem_we    <= 1'b1;
        bus.imem_addr  <= words_loaded[ADDR_WIDTH-1:0];
        bus.imem_wdata <= word;
        words_loaded   <= words_next;
      end
    end
  end

  assign bus.in_ready = is_loading(state);
  assign busy         = is_loading(state);
  assign cpu_reset    = (state != ST_DONE);
  assign done         = (state == ST_DONE);
  assign error        = (state == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed frame table, hand-written
// corner sequences and random frames against a frame-level reference model.
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic          exp_done;
  logic          exp_error;
  int            exp_words;

  // Every write strobe seen is logged for comparison against the model.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
  end

  typedef struct {
    string       name;
    int          nbytes;
    logic [95:0] bytes;
    bit          gapped;
    int          start_at;
    logic        exp_done;
    logic        exp_error;
    int          exp_words;
  } vec_t;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: a frame's effect derived straight from its byte layout.
  task automatic run_model(input logic [7:0] f[$]);
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    n = {16'h0, f[0], f[1]};
    if (n > (1 << AW)) begin
      exp_done  = 1'b0;
      exp_error = 1'b1;
      exp_words = 0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(AW'(i));
      exp_data.push_back({f[2+4*i], f[3+4*i], f[4+4*i], f[5+4*i]});
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x ^= f[i];
    exp_words = n;
    exp_done  = (f[2+4*n] == x);
    exp_error = !exp_done;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] f[$], input bit gapped, input int start_at);
    int  n;
    bit  ok;
    int  idle;
    logic exp_we;
    n  = {16'h0, f[0], f[1]};
    ok = (n <= (1 << AW));
    for (int k = 0; k < f.size(); k++) begin
      if (gapped) begin
        idle = (k % 2) + $urandom_range(0, 2);
        repeat (idle) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 8'($urandom);
          @(posedge clk);
          @(negedge clk);
        end
      end
      if (k == start_at) begin
        bus.in_valid = 1'b0;
        pulse_start();
      end
      check_output("in_ready_during_frame", bus.in_ready, 1'b1);
      check_output("cpu_reset_during_frame", cpu_reset, 1'b1);
      if (bus.in_ready !== 1'b1) break;
      bus.in_valid = 1'b1;
      bus.in_data  = f[k];
      @(posedge clk);
      @(negedge clk);
      exp_we = ok && (k >= 2) && (k < 2 + 4 * n) && (((k - 2) % 4) == 3);
      check_output("imem_we_timing", bus.imem_we, exp_we);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [7:0] f[$], input bit gapped, input int start_at);
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    check_output("busy_after_start", busy, 1'b1);
    check_output("cpu_reset_after_start", cpu_reset, 1'b1);
    check_output("words_loaded_after_start", words_loaded, 0);
    send_bytes(f, gapped, start_at);
    run_model(f);
  endtask

  task automatic check_status(input logic e_done, input logic e_error, input int e_words);
    check_output("done", done, e_done);
    check_output("error", error, e_error);
    check_output("cpu_reset", cpu_reset, !e_done);
    check_output("busy_end", busy, 1'b0);
    check_output("in_ready_end", bus.in_ready, 1'b0);
    check_output("words_loaded", words_loaded, e_words);
    check_output("write_count", wr_addr.size(), exp_addr.size());
    for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
      check_output("write_addr", wr_addr[i], exp_addr[i]);
      check_output("write_data", wr_data[i], exp_data[i]);
    end
    repeat (2) @(negedge clk);
    check_output("done_sticky", done, e_done);
    check_output("error_sticky", error, e_error);
  endtask

  task automatic check_reset_values();
    check_output("rst_cpu_reset", cpu_reset, 1'b1);
    check_output("rst_in_ready", bus.in_ready, 1'b0);
    check_output("rst_imem_we", bus.imem_we, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_done", done, 1'b0);
    check_output("rst_error", error, 1'b0);
    check_output("rst_imem_addr", bus.imem_addr, 0);
    check_output("rst_imem_wdata", bus.imem_wdata, 0);
    check_output("rst_words_loaded", words_loaded, 0);
  endtask

  vec_t         vecs[6];
  logic [7:0]   f[$];
  logic [7:0]   good[$];
  logic [7:0]   x;
  int           n;

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    vecs[0] = '{"good_2word", 11, 96'h00022001000520020007_03, 1'b0, -1, 1'b1, 1'b0, 2};
    vecs[1] = '{"bad_csum",   11, 96'h00022001000520020007_04, 1'b0, -1, 1'b0, 1'b1, 2};
    vecs[2] = '{"oversize",    2, 96'h0101,                    1'b0, -1, 1'b0, 1'b1, 0};
    vecs[3] = '{"empty",       3, 96'h000000,                  1'b0, -1, 1'b1, 1'b0, 0};
    vecs[4] = '{"one_word",    7, 96'h0001DEADBEEF23,          1'b0, -1, 1'b1, 1'b0, 1};
    vecs[5] = '{"good_gapped",11, 96'h00022001000520020007_03, 1'b1,  6, 1'b1, 1'b0, 2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      f.delete();
      for (int k = 0; k < vecs[v].nbytes; k++)
        f.push_back(vecs[v].bytes[8*(vecs[v].nbytes-1-k) +: 8]);
      $display("[TB] vector %s", vecs[v].name);
      apply_stimulus(f, vecs[v].gapped, vecs[v].start_at);
      check_status(vecs[v].exp_done, vecs[v].exp_error, vecs[v].exp_words);
      if (v == 0 && wr_data.size() == 2) begin
        check_output("good_word0", wr_data[0], 32'h20010005);
        check_output("good_word1", wr_data[1], 32'h20020007);
      end
    end

    // Reset in the middle of the first word, then a clean reload.
    good.delete();
    for (int k = 0; k < 11; k++) good.push_back(vecs[0].bytes[8*(10-k) +: 8]);
    f.delete();
    for (int k = 0; k < 4; k++) f.push_back(good[k]);
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    send_bytes(f, 1'b0, -1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    @(negedge clk);
    check_output("reset_mid_word_writes", wr_addr.size(), 0);
    apply_stimulus(good, 1'b0, -1);
    check_status(1'b1, 1'b0, 2);

    // Largest legal program fills memory up to the all-ones address.
    f.delete();
    f.push_back(8'h01);
    f.push_back(8'h00);
    for (int k = 0; k < 4 * (1 << AW); k++) f.push_back(8'($urandom));
    x = 8'h00;
    foreach (f[k]) x ^= f[k];
    f.push_back(x);
    apply_stimulus(f, 1'b0, -1);
    check_status(exp_done, exp_error, exp_words);
    check_output("full_words_loaded", words_loaded, 9'h100);
    if (wr_addr.size() == (1 << AW))
      check_output("full_last_addr", wr_addr[(1 << AW) - 1], 8'hFF);

    // Random frames: short programs, occasional oversize or bad checksum.
    for (int t = 0; t < 25; t++) begin
      f.delete();
      if ($urandom_range(0, 7) == 0) begin
        n = 257 + $urandom_range(0, 60000);
        f.push_back(n[15:8]);
        f.push_back(n[7:0]);
      end else begin
        n = $urandom_range(0, 6);
        f.push_back(n[15:8]);
        f.push_back(n[7:0]);
        for (int k = 0; k < 4 * n; k++) f.push_back(8'($urandom));
        x = 8'h00;
        foreach (f[k]) x ^= f[k];
        if ($urandom_range(0, 3) == 0) x ^= 8'(1 + $urandom_range(0, 254));
        f.push_back(x);
      end
      apply_stimulus(f, 1'($urandom_range(0, 1)), -1);
      check_status(exp_done, exp_error, exp_words);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader for the single-cycle MIPS CPU. It is the writer side of the instruction memory that the CPU reads.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Writes them to consecutive instruction-memory word addresses.
- Holds the CPU in reset until a load completes with a correct checksum. Replaces hard-coded memory initialisation in simulation and on FPGA.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; depth = 2**ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- in_valid  in  1  the byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  instruction word.
- cpu_reset  out  1  reset to the mips_cpu; high until load succeeds.
- busy  out  1  load in progress (states LEN_HI through CSUM).
- done  out  1  load completed with a good checksum.
- error  out  1  load aborted (checksum mismatch or oversize length).
- words_loaded  out  ADDR_WIDTH+1  number of words written so far.

Behaviour:
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes, each word MSB first, then one checksum byte.
- Checksum rule: the checksum byte must equal the XOR of every preceding frame byte, including both length bytes.
- Transfer rule: a byte transfers on a rising edge where in_valid & in_ready. in_valid may drop at any time, and gaps are allowed.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR.
  - IDLE, DONE or ERROR, start=1 -> LEN_HI. Clears byte counter, words_loaded and the XOR accumulator.
  - LEN_HI, byte transferred -> LEN_LO.
  - LEN_LO, byte transferred, with N = {hi, lo}:
    - N > 2**ADDR_WIDTH -> ERROR.
    - N = 0 -> CSUM.
    - otherwise -> DATA.
  - DATA: shift each byte into a 32-bit assembly register. On the 4th byte of a word, register imem_wdata and imem_addr = words_loaded[ADDR_WIDTH-1:0], then increment words_loaded. When words_loaded reaches N -> CSUM.
  - CSUM, byte transferred: byte == accumulator -> DONE; otherwise -> ERROR.
  - DONE and ERROR are sticky until start or reset.
- in_ready = 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 elsewhere. No internal backpressure.
- imem_we is registered: it is high for exactly the cycle after the edge that transfers byte 3 of a word, with addr and wdata stable in that cycle. Words already written before an ERROR remain in memory; there is no rollback.
- Status outputs are Moore-decoded from the state register:
  - cpu_reset = 1 in every state except DONE.
  - done = (state==DONE).
  - error = (state==ERROR).
  - busy = in_ready.
- Latency: cpu_reset falls in the cycle following the edge that accepts a correct checksum byte.
- start while busy is ignored. start in DONE reasserts cpu_reset on the next cycle.
- Reset values:
  - state IDLE, cpu_reset=1.
  - in_ready, imem_we, busy, done, error = 0.
  - imem_addr, imem_wdata, words_loaded = 0.
- Reset mid-load aborts immediately. Any pending write strobe is suppressed (imem_we=0 in the cycle after reset) and the partial word is discarded.
- N = 2**ADDR_WIDTH is legal: the last address written is all-ones, and words_loaded reaches 2**ADDR_WIDTH without wrap.

Decomposition:
- Shared package mips_pkg:
  - loader state enum (3-bit encoding).
  - INSTR_WIDTH=32 and BYTES_PER_WORD=4 constants.
  - LEN_WIDTH=16.
- One natural sub-module: loader_word_assembler. It holds the byte counter and shift register, and outputs word_valid and word. The top level holds the FSM, length compare, XOR accumulator and address counter.

Test Plan:
- Good 2-word load:
  - Stimulus: start, then bytes 00 02 20 01 00 05 20 02 00 07 03, in_valid held high.
  - Required: writes [0]=20010005 and [1]=20020007, one imem_we cycle each; then done=1, words_loaded=2, cpu_reset falls the cycle after byte 03 is accepted.
- Bad checksum:
  - Stimulus: same frame with final byte 04.
  - Required: both words written, then error=1, done=0, cpu_reset stays 1; a later start re-enters LEN_HI with words_loaded=0.
- Oversize length with ADDR_WIDTH=8:
  - Stimulus: bytes 01 01 (N=257).
  - Required: ERROR after LEN_LO, in_ready=0, no imem_we ever asserted.
- Empty program:
  - Stimulus: bytes 00 00 00.
  - Required: no writes, done=1, words_loaded=0, cpu_reset=0.
- Gapped valid:
  - Stimulus: the good 2-word frame with in_valid low on alternate cycles and random stalls.
  - Required: identical writes and final status as the good-load case, with exactly 2 write strobes.
- Reset mid-word:
  - Stimulus: reset asserted after bytes 00 02 20 01, then start and a full good frame.
  - Required: no write for the partial word, outputs at reset values; the second load completes as in the good-load case.
